link_master_fsm: RTL and testbench

Initiator end of the 4-phase req/ack byte link. On a start command it transfers a burst of BURST_LEN bytes (base, base+1, …) to the responder, one byte per full handshake. It raises req with stable data, waits for ack high, drops req, waits for ack low, then moves to the next byte. It sits opposite the link responder in the same clock domain and reports completion, progress and (optionally) a handshake timeout.

---
 rtl/link_pkg.sv | 17 +
 rtl/link_master_fsm_if.sv | 18 +
 rtl/link_timeout_ctr.sv | 35 +++
 rtl/link_master_fsm.sv | 136 +++++++++++++
 tb/tb_link_master_fsm.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared types and constants for the req/ack byte link.
//   state_e     : initiator FSM states (IDLE, WAIT_ACK_HI, WAIT_ACK_LO, ERR)
//   LINK_DATA_W : default link data width
//   BYTE_CNT_W  : width of the transferred-byte counter and timeout counter
package link_pkg;

  localparam int unsigned LINK_DATA_W = 8;
  localparam int unsigned BYTE_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2,
    ERR         = 2'd3
  } state_e;

endpackage

// File: rtl/link_master_fsm_if.sv
// link_if: 4-phase req/ack byte link.
//   req  : request, driven by the initiator
//   data : byte on the link, driven by the initiator, stable while req=1
//          and until ack returns low
//   ack  : acknowledge, driven by the responder
// Modports: master (initiator side), slave (responder side).
interface link_if import link_pkg::*; #(
  parameter int unsigned DATA_W = LINK_DATA_W
) ();

  logic              req;
  logic              ack;
  logic [DATA_W-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);

endinterface

// File: rtl/link_timeout_ctr.sv
// link_timeout_ctr: wait-cycle counter for the link initiator.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset
//   clr     : clears the count (state change this cycle)
//   en      : count this cycle (FSM is waiting on an ack edge)
//   expired : the current wait cycle is the TIMEOUT_CYC-th one
module link_timeout_ctr import link_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [BYTE_CNT_W-1:0] LAST_CNT = BYTE_CNT_W'(TIMEOUT_CYC - 1);

  logic [BYTE_CNT_W-1:0] cnt;

  // Expiry is flagged on the edge that would make the count reach
  // TIMEOUT_CYC, so the FSM leaves after exactly TIMEOUT_CYC wait cycles.
  assign expired = en && !clr && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/link_master_fsm.sv
// link_master_fsm: initiator end of the 4-phase req/ack byte link.
// On start it sends BURST_LEN bytes (base, base+1, ...) one per full
// handshake: raise req with data, wait ack high, drop req, wait ack low.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : burst request, sampled in IDLE (and ERR)
//   base     : first byte of the burst, captured on accepted start
//   lnk      : link_if.master (req, data out; ack in)
//   busy     : burst in progress
//   done     : one-cycle pulse after the final handshake
//   byte_cnt : bytes fully transferred in the current or last burst
//   err      : sticky handshake-timeout flag
// Optional feature macro: LINK_MASTER_TIMEOUT_EN enables a per-edge wait
// timeout (TIMEOUT_CYC cycles) that aborts into ERR; otherwise the FSM
// waits on ack indefinitely and err stays 0.
module link_master_fsm import link_pkg::*; #(
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned DATA_W      = LINK_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     base,
  link_if.master                lnk,
  output logic                  busy,
  output logic                  done,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  err
);

  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("link_master_fsm: BURST_LEN must be 1..255");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("link_master_fsm: TIMEOUT_CYC must be 2..255");
  end

  localparam logic [BYTE_CNT_W-1:0] BURST_LAST = BYTE_CNT_W'(BURST_LEN);

  state_e                state;
  logic [BYTE_CNT_W-1:0] cnt_next;
  logic                  last_byte;
  logic                  expired;

  assign cnt_next  = byte_cnt + 1'b1;
  assign last_byte = (cnt_next >= BURST_LAST);

`ifdef LINK_MASTER_TIMEOUT_EN
  logic waiting;
  logic state_chg;

  assign waiting = (state == WAIT_ACK_HI) || (state == WAIT_ACK_LO);

  // Mirrors the FSM's transition conditions so the counter restarts on the
  // same edge the state changes; outside the wait states it is held clear.
  always_comb begin
    state_chg = 1'b1;
    case (state)
      WAIT_ACK_HI: state_chg = lnk.ack;
      WAIT_ACK_LO: state_chg = !lnk.ack;
      default:     state_chg = 1'b1;
    endcase
  end

  link_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_chg),
    .en      (waiting),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lnk.req  <= 1'b0;
      lnk.data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            lnk.data <= base;
            lnk.req  <= 1'b1;
            busy     <= 1'b1;
            byte_cnt <= '0;
            err      <= 1'b0;
            state    <= WAIT_ACK_HI;
          end
        end
        WAIT_ACK_HI: begin
          if (lnk.ack) begin
            lnk.req <= 1'b0;
            state   <= WAIT_ACK_LO;
          end else if (expired) begin
            lnk.req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= ERR;
          end
        end
        WAIT_ACK_LO: begin
          if (!lnk.ack) begin
            byte_cnt <= cnt_next;
            if (!last_byte) begin
              lnk.data <= lnk.data + 1'b1;
              lnk.req  <= 1'b1;
              state    <= WAIT_ACK_HI;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else if (expired) begin
            lnk.req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_master_fsm.sv
module tb_link_master_fsm;
  import link_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base;
  logic       busy;
  logic       done;
  logic [7:0] byte_cnt;
  logic       err;

  int n_cmp;
  int n_fail;
  int done_seen;

  logic [7:0] cap  [4];
  logic [7:0] hold [4];
  bit         to_flag;

  link_if #(.DATA_W(8)) lnk ();

  link_master_fsm #(
    .BURST_LEN   (4),
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .lnk      (lnk),
    .busy     (busy),
    .done     (done),
    .byte_cnt (byte_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  // Responder: per byte waits for req (bounded), acks one cycle later,
  // holds ack for two sampled edges, then releases it.
  task automatic serve(input int n);
    to_flag = 1'b0;
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      while (lnk.req !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
      if (lnk.req !== 1'b1) begin
        to_flag = 1'b1;
        return;
      end
      cap[i] = lnk.data;
      tick();
      lnk.ack = 1'b1;
      tick();
      tick();
      hold[i] = lnk.data;
      lnk.ack = 1'b0;
      tick();
    end
  endtask

  task automatic launch(input logic [7:0] b);
    base  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base = 8'h00; lnk.ack = 1'b0;
    tick(); tick();
    n_cmp++; if (lnk.req !== 1'b0)   begin n_fail++; $display("FAIL reset_req got %b exp 0", lnk.req); end
    n_cmp++; if (lnk.data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", lnk.data); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (byte_cnt !== 8'd0)  begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", byte_cnt); end
    n_cmp++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b1;
    tick();
    // ack high in IDLE must not disturb anything
    lnk.ack = 1'b1;
    tick(); tick();
    lnk.ack = 1'b0;
    n_cmp++; if (lnk.req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack req=%b busy=%b exp 0 0", lnk.req, busy); end
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    done_seen = 0;
    launch(8'hA0);
    n_cmp++; if (lnk.req !== 1'b1)   begin n_fail++; $display("FAIL basic_req_rise got %b exp 1", lnk.req); end
    n_cmp++; if (lnk.data !== 8'hA0) begin n_fail++; $display("FAIL basic_first_data got %h exp a0", lnk.data); end
    n_cmp++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    n_cmp++; if (byte_cnt !== 8'd0)  begin n_fail++; $display("FAIL basic_cnt0 got %0d exp 0", byte_cnt); end
    serve(4);
    n_cmp++; if (to_flag !== 1'b0) begin n_fail++; $display("FAIL basic_req_wait got timeout exp req"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cap[i] !== exp_d[i])  begin n_fail++; $display("FAIL basic_data[%0d] got %h exp %h", i, cap[i], exp_d[i]); end
      n_cmp++; if (hold[i] !== exp_d[i]) begin n_fail++; $display("FAIL basic_hold[%0d] got %h exp %h", i, hold[i], exp_d[i]); end
    end
    n_cmp++; if (done !== 1'b1)     begin n_fail++; $display("FAIL basic_done got %b exp 1", done); end
    n_cmp++; if (byte_cnt !== 8'd4) begin n_fail++; $display("FAIL basic_cnt got %0d exp 4", byte_cnt); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    tick();
    n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL basic_done_clr got %b exp 0", done); end
    n_cmp++; if (done_seen !== 1)   begin n_fail++; $display("FAIL basic_done_pulses got %0d exp 1", done_seen); end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    launch(8'hFE);
    serve(4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cap[i] !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", i, cap[i], exp_d[i]); end
    end
    n_cmp++; if (byte_cnt !== 8'd4) begin n_fail++; $display("FAIL wrap_cnt got %0d exp 4", byte_cnt); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    launch(8'h10);
    // start while busy: must be ignored
    launch(8'h55);
    n_cmp++; if (lnk.data !== 8'h10) begin n_fail++; $display("FAIL b2b_ignore_data got %h exp 10", lnk.data); end
    serve(4);
    n_cmp++; if (cap[3] !== 8'h13) begin n_fail++; $display("FAIL b2b_first_last got %h exp 13", cap[3]); end
    n_cmp++; if (done !== 1'b1)    begin n_fail++; $display("FAIL b2b_done got %b exp 1", done); end
    // start in the done cycle is accepted immediately
    launch(8'h80);
    n_cmp++; if (lnk.req !== 1'b1)   begin n_fail++; $display("FAIL b2b_restart_req got %b exp 1", lnk.req); end
    n_cmp++; if (lnk.data !== 8'h80) begin n_fail++; $display("FAIL b2b_restart_data got %h exp 80", lnk.data); end
    n_cmp++; if (byte_cnt !== 8'd0)  begin n_fail++; $display("FAIL b2b_restart_cnt got %0d exp 0", byte_cnt); end
    n_cmp++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL b2b_restart_busy got %b exp 1", busy); end
    serve(4);
    n_cmp++; if (cap[3] !== 8'h83)  begin n_fail++; $display("FAIL b2b_second_last got %h exp 83", cap[3]); end
    n_cmp++; if (byte_cnt !== 8'd4) begin n_fail++; $display("FAIL b2b_second_cnt got %0d exp 4", byte_cnt); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    launch(8'h30);
    serve(1);
    n_cmp++; if (lnk.req !== 1'b1 || lnk.data !== 8'h31 || byte_cnt !== 8'd1) begin
      n_fail++; $display("FAIL mid_pre req=%b data=%h cnt=%0d exp 1 31 1", lnk.req, lnk.data, byte_cnt);
    end
    done_seen = 0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (lnk.req !== 1'b0)   begin n_fail++; $display("FAIL mid_req got %b exp 0", lnk.req); end
    n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_cmp++; if (lnk.data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h exp 00", lnk.data); end
    n_cmp++; if (byte_cnt !== 8'd0)  begin n_fail++; $display("FAIL mid_cnt got %0d exp 0", byte_cnt); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (done_seen !== 0 || lnk.req !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_done done_seen=%0d req=%b exp 0 0", done_seen, lnk.req);
    end
    launch(8'h40);
    serve(4);
    n_cmp++; if (cap[0] !== 8'h40 || cap[3] !== 8'h43) begin n_fail++; $display("FAIL mid_after got %h..%h exp 40..43", cap[0], cap[3]); end
    n_cmp++; if (done !== 1'b1 || byte_cnt !== 8'd4)  begin n_fail++; $display("FAIL mid_after_done done=%b cnt=%0d exp 1 4", done, byte_cnt); end
    tick(); tick();
  endtask

`ifdef LINK_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    launch(8'h70);
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (lnk.req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL to_early req=%b err=%b exp 1 0", lnk.req, err); end
    tick();
    n_cmp++; if (lnk.req !== 1'b0) begin n_fail++; $display("FAIL to_req got %b exp 0", lnk.req); end
    n_cmp++; if (err !== 1'b1)     begin n_fail++; $display("FAIL to_err got %b exp 1", err); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL to_busy_done got %b %b exp 0 0", busy, done); end
    launch(8'h20);
    n_cmp++; if (err !== 1'b0 || lnk.req !== 1'b1) begin n_fail++; $display("FAIL to_restart err=%b req=%b exp 0 1", err, lnk.req); end
    serve(4);
    n_cmp++; if (cap[3] !== 8'h23 || done !== 1'b1) begin n_fail++; $display("FAIL to_recover last=%h done=%b exp 23 1", cap[3], done); end
    tick(); tick();
  endtask

  task automatic test_stuck_ack();
    launch(8'h90);
    lnk.ack = 1'b1;
    tick();
    n_cmp++; if (lnk.req !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL stuck_lo req=%b err=%b exp 0 0", lnk.req, err); end
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL stuck_early got %b exp 0", err); end
    tick();
    n_cmp++; if (err !== 1'b1)      begin n_fail++; $display("FAIL stuck_err got %b exp 1", err); end
    n_cmp++; if (byte_cnt !== 8'd0) begin n_fail++; $display("FAIL stuck_cnt got %0d exp 0", byte_cnt); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL stuck_busy got %b exp 0", busy); end
    lnk.ack = 1'b0;
    tick(); tick();
  endtask
`else
  task automatic test_no_timeout();
    launch(8'h60);
    for (int i = 0; i < 40; i++) tick();
    n_cmp++; if (lnk.req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL nto_wait req=%b busy=%b exp 1 1", lnk.req, busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL nto_err got %b exp 0", err); end
    serve(4);
    n_cmp++; if (cap[3] !== 8'h63 || done !== 1'b1) begin n_fail++; $display("FAIL nto_finish last=%h done=%b exp 63 1", cap[3], done); end
    tick(); tick();
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    done_seen = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef LINK_MASTER_TIMEOUT_EN
    test_timeout();
    test_stuck_ack();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
